// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequences one ALU operation at a time, holding operands for a settle time and returning Z.
// Optional macro ALU_ISSUE_DIV0_CHECK_EN traps div-by-zero (op 15, B==0) with rsp_err instead of issuing it.
module alu_issue_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int SEL_WIDTH   = 16,
    parameter int OP_WAIT     = 0,
    parameter int MULDIV_WAIT = 4
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SEL_WIDTH-1:0]  req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [SEL_WIDTH-1:0]  alu_sel,
    input  logic [DATA_WIDTH-1:0] alu_zhigh,
    input  logic [DATA_WIDTH-1:0] alu_zlow,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_hi,
    output logic [DATA_WIDTH-1:0] rsp_lo,
    output logic                  rsp_err,
    output logic                  busy
);
    localparam int MAXW = OP_WAIT > MULDIV_WAIT ? OP_WAIT : MULDIV_WAIT;
    localparam int CW   = $clog2(MAXW + 1) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic take, legal, muldiv, trap, active;

    assign take   = req_valid && state == IDLE;
    assign legal  = req_op != '0 && req_op <= SEL_WIDTH'(15);
    assign muldiv = req_op == SEL_WIDTH'(14) || req_op == SEL_WIDTH'(15);
    assign active = state == ISSUE || state == WAIT;
`ifdef ALU_ISSUE_DIV0_CHECK_EN
    assign trap = !legal || (req_op == SEL_WIDTH'(15) && req_b == '0);
`else
    assign trap = !legal;
`endif

    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign busy      = state != IDLE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:        state_nx = take ? (trap ? RESP : ISSUE) : IDLE;
            ISSUE, WAIT: state_nx = cnt == '0 ? RESP : WAIT;
            RESP:        state_nx = rsp_ready ? IDLE : RESP;
            default:     state_nx = IDLE;
        endcase
    end

    // alu_sel is a register so an asynchronous clear drops it to 0 at once
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state   <= IDLE;
            cnt     <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            rsp_hi  <= '0;
            rsp_lo  <= '0;
            rsp_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (take && trap) begin
                rsp_hi  <= '0;
                rsp_lo  <= '0;
                rsp_err <= 1'b1;
            end else if (take) begin
                alu_a   <= req_a;
                alu_b   <= req_b;
                alu_sel <= req_op;
                cnt     <= muldiv ? CW'(MULDIV_WAIT) : CW'(OP_WAIT);
            end
            if (active && cnt == '0) begin
                rsp_hi  <= alu_zhigh;
                rsp_lo  <= alu_zlow;
                rsp_err <= 1'b0;
                alu_sel <= '0;
            end else if (active) begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vectors against alu_issue_ctrl with a small behavioural ALU on its outputs.
module tb_alu_issue_ctrl;
    logic        clock = 1'b0;
    logic        clear;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, busy;
    logic [15:0] req_op, alu_sel;
    logic [31:0] req_a, req_b, alu_a, alu_b, alu_zhigh, alu_zlow, rsp_hi, rsp_lo;
    logic [63:0] z;
    int n_vec = 0, n_err = 0;
    int lat, sel_cyc;
    bit stable;
    logic [31:0] held;

    alu_issue_ctrl dut (
        .clock(clock), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sel(alu_sel), .alu_zhigh(alu_zhigh), .alu_zlow(alu_zlow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clock = ~clock;

    // Behavioural ALU: and, xor, add, mul, div (div by zero gives hi=A, lo=all ones)
    always_comb begin
        z = '0;
        case (alu_sel)
            16'd1:   z = {32'd0, alu_a & alu_b};
            16'd4:   z = {32'd0, alu_a ^ alu_b};
            16'd12:  z = {32'd0, alu_a + alu_b};
            16'd14:  z = 64'(alu_a) * 64'(alu_b);
            16'd15:  z = alu_b == '0 ? {alu_a, 32'hFFFF_FFFF} : {alu_a % alu_b, alu_a / alu_b};
            default: z = '0;
        endcase
    end
    assign alu_zhigh = z[63:32];
    assign alu_zlow  = z[31:0];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic run(input logic [15:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lt, output int sc, output bit st);
        logic [31:0] a0, b0;
        logic [15:0] s0;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        tick;
        req_valid = 1'b0;
        lt = 1; sc = int'(alu_sel != '0); st = 1'b1;
        a0 = alu_a; b0 = alu_b; s0 = alu_sel;
        while (!rsp_valid && lt < 50) begin
            tick;
            lt++;
            if (alu_sel != '0) begin
                sc++;
                if (alu_a != a0 || alu_b != b0 || alu_sel != s0) st = 1'b0;
            end
        end
    endtask

    task automatic drain;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check("drop_valid", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        clear = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0;
        #12;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_sel", 64'(alu_sel), 64'd0);
        check("rst_rsp", {rsp_hi, rsp_lo}, 64'd0);
        check("rst_err", 64'(rsp_err), 64'd0);
        clear = 1'b0;
        tick;

        // add, OP_WAIT=0
        req_valid = 1'b1; req_op = 16'd12; req_a = 32'd5; req_b = 32'd7; rsp_ready = 1'b1;
        tick;
        req_valid = 1'b0;
        check("add_sel_issue", 64'(alu_sel), 64'd12);
        check("add_busy", 64'(busy), 64'd1);
        check("add_ready_low", 64'(req_ready), 64'd0);
        check("add_no_valid", 64'(rsp_valid), 64'd0);
        tick;
        check("add_valid", 64'(rsp_valid), 64'd1);
        check("add_sel_resp", 64'(alu_sel), 64'd0);
        check("add_result", {rsp_hi, rsp_lo}, 64'd12);
        check("add_err", 64'(rsp_err), 64'd0);
        tick;
        rsp_ready = 1'b0;
        check("add_drop", 64'(rsp_valid), 64'd0);
        check("add_idle", 64'(req_ready), 64'd1);

        // mul, MULDIV_WAIT=4
        run(16'd14, 32'h0001_0000, 32'h0001_0000, lat, sel_cyc, stable);
        check("mul_lat", 64'(lat), 64'd6);
        check("mul_sel_cyc", 64'(sel_cyc), 64'd5);
        check("mul_stable", 64'(stable), 64'd1);
        check("mul_result", {rsp_hi, rsp_lo}, 64'h0000_0001_0000_0000);
        check("mul_err", 64'(rsp_err), 64'd0);
        drain;

        // illegal ops 0 and 16
        run(16'd0, 32'd3, 32'd4, lat, sel_cyc, stable);
        check("op0_lat", 64'(lat), 64'd1);
        check("op0_sel", 64'(sel_cyc), 64'd0);
        check("op0_err", 64'(rsp_err), 64'd1);
        check("op0_result", {rsp_hi, rsp_lo}, 64'd0);
        drain;
        run(16'd16, 32'd3, 32'd4, lat, sel_cyc, stable);
        check("op16_lat", 64'(lat), 64'd1);
        check("op16_sel", 64'(sel_cyc), 64'd0);
        check("op16_err", 64'(rsp_err), 64'd1);
        check("op16_result", {rsp_hi, rsp_lo}, 64'd0);
        drain;

        // backpressure with a second request waiting
        run(16'd4, 32'hFF00_FF00, 32'h0F0F_0F0F, lat, sel_cyc, stable);
        check("xor_lat", 64'(lat), 64'd2);
        check("xor_result", 64'(rsp_lo), 64'hF00F_F00F);
        check("xor_err_cleared", 64'(rsp_err), 64'd0);
        req_valid = 1'b1; req_op = 16'd1; req_a = 32'h0000_F0F0; req_b = 32'h0000_FF00;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_lo", 64'(rsp_lo), 64'hF00F_F00F);
            check("bp_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check("bp_idle_ready", 64'(req_ready), 64'd1);
        check("bp_drop", 64'(rsp_valid), 64'd0);
        tick;
        req_valid = 1'b0;
        check("bp_second_sel", 64'(alu_sel), 64'd1);
        check("bp_second_busy", 64'(busy), 64'd1);
        lat = 1;
        while (!rsp_valid && lat < 50) begin tick; lat++; end
        check("and_lat", 64'(lat), 64'd2);
        check("and_result", {rsp_hi, rsp_lo}, 64'h0000_F000);
        drain;

        // clear in the middle of a divide
        req_valid = 1'b1; req_op = 16'd15; req_a = 32'd100; req_b = 32'd7;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
        check("div_mid_sel", 64'(alu_sel), 64'd15);
        clear = 1'b1;
        #1;
        check("clr_sel", 64'(alu_sel), 64'd0);
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_ready", 64'(req_ready), 64'd1);
        check("clr_rsp", {rsp_hi, rsp_lo}, 64'd0);
        check("clr_ab", {alu_a, alu_b}, 64'd0);
        tick;
        clear = 1'b0;
        stable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (rsp_valid) stable = 1'b1;
        end
        check("clr_no_rsp", 64'(stable), 64'd0);
        run(16'd1, 32'h0000_000F, 32'h0000_003C, lat, sel_cyc, stable);
        check("post_clr_lat", 64'(lat), 64'd2);
        check("post_clr_result", {rsp_hi, rsp_lo}, 64'h0000_000C);
        drain;

        // divide, normal then by zero
        run(16'd15, 32'd100, 32'd7, lat, sel_cyc, stable);
        check("div_lat", 64'(lat), 64'd6);
        check("div_result", {rsp_hi, rsp_lo}, {32'd2, 32'd14});
        drain;
        run(16'd15, 32'd9, 32'd0, lat, sel_cyc, stable);
`ifdef ALU_ISSUE_DIV0_CHECK_EN
        check("div0_lat", 64'(lat), 64'd1);
        check("div0_sel", 64'(sel_cyc), 64'd0);
        check("div0_err", 64'(rsp_err), 64'd1);
        check("div0_result", {rsp_hi, rsp_lo}, 64'd0);
`else
        check("div0_lat", 64'(lat), 64'd6);
        check("div0_sel", 64'(sel_cyc), 64'd5);
        check("div0_err", 64'(rsp_err), 64'd0);
        check("div0_result", {rsp_hi, rsp_lo}, {32'd9, 32'hFFFF_FFFF});
`endif
        drain;

        // rsp_ready asserted while idle is ignored
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check("idle_rsp_ready", 64'(rsp_valid), 64'd0);
        held = rsp_lo;
        check("idle_ready", 64'(req_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencing front-end that drives the datapath ALU (operands A/B, 16-bit op select) and collects its 64-bit ZHigh/ZLow result.
- Accepts one operation request at a time over a valid/ready handshake.
- Holds operands and select stable for a programmable settle time (longer for the combinational mul/div paths), captures Z, and returns it over a valid/ready response handshake.
- Sits between the control unit and the ALU; owns the ALU's multicycle-path timing.

Parameters:
- DATA_WIDTH, 32, operand and half-result width.
- SEL_WIDTH, 16, ALU select width.
- OP_WAIT, 0, extra hold cycles for op codes 1..13.
- MULDIV_WAIT, 4, extra hold cycles for op codes 14 (mul) and 15 (div).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  SEL_WIDTH  ALU op code; legal values are 1..15.
- req_a  in  DATA_WIDTH  operand A.
- req_b  in  DATA_WIDTH  operand B.
- alu_a  out  DATA_WIDTH  to ALU A.
- alu_b  out  DATA_WIDTH  to ALU B.
- alu_sel  out  SEL_WIDTH  to ALU select.
- alu_zhigh  in  DATA_WIDTH  from ALU ZHigh.
- alu_zlow  in  DATA_WIDTH  from ALU ZLow.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_hi  out  DATA_WIDTH  captured ZHigh.
- rsp_lo  out  DATA_WIDTH  captured ZLow.
- rsp_err  out  1  request rejected (illegal op, or div-by-zero when enabled).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Single clock domain (clock). clear is asynchronous and active-high; while asserted, every register is at its reset value.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, busy=0, and alu_a, alu_b, alu_sel, rsp_hi, rsp_lo all 0.
- All outputs are registered or decoded from state only; there is no combinational path from req_* to alu_* or rsp_*.
- IDLE:
  - req_ready=1, alu_sel=0.
  - On req_valid && req_ready, latch req_a, req_b and req_op.
  - If op is 0 or greater than 15: go to RESP with rsp_err=1 and rsp_hi=rsp_lo=0; the ALU is never driven.
  - Otherwise: go to ISSUE, and load the wait counter with MULDIV_WAIT if op is 14 or 15, else OP_WAIT.
- ISSUE / WAIT:
  - req_ready=0.
  - alu_a, alu_b and alu_sel are driven from the latched values and held constant.
  - Each cycle: if counter==0, capture alu_zhigh into rsp_hi and alu_zlow into rsp_lo, set rsp_err=0, and go to RESP. Otherwise decrement the counter and stay in (or enter) WAIT.
- RESP:
  - rsp_valid=1.
  - alu_sel returns to 0; alu_a and alu_b may hold.
  - rsp_hi, rsp_lo and rsp_err are stable until the handshake completes.
  - On rsp_ready: go to IDLE and drop rsp_valid next cycle. No new request is accepted in that same cycle (no bypass).
- Latency: request accepted at edge N; result captured at edge N+1+W; rsp_valid high from cycle N+2+W. W is the selected wait value.
- Throughput: one operation per 3+W cycles minimum, when rsp_ready is held high.
- Counter width: clog2 of the larger wait value plus 1. A wait value of 0 is legal.
- rsp_ready asserted outside RESP is ignored. req_valid outside IDLE is ignored; the requester holds its request until req_ready.
- clear asserted mid-operation aborts immediately: no response is produced, and the ALU select goes to 0 asynchronously.
- Op 13 (sub): the block drives B unmodified; the carry-in/inversion is the ALU's responsibility.

Optional Feature:
- Macro: ALU_ISSUE_DIV0_CHECK_EN.
- Defined: op 15 with req_b==0 is trapped in IDLE. The block goes directly to RESP with rsp_err=1 and rsp_hi=rsp_lo=0, and the ALU is never driven.
- Undefined: divide-by-zero is issued normally and whatever the ALU produces is returned with rsp_err=0.

Test Plan:
- Add, OP_WAIT=0: op=12, A=5, B=7, rsp_ready=1 -> rsp_lo=12, rsp_hi=0, rsp_err=0; rsp_valid rises 2 cycles after acceptance; alu_sel=12 for exactly 1 cycle.
- Mul, MULDIV_WAIT=4: op=14, A=0x00010000, B=0x00010000 -> rsp_hi=0x00000001, rsp_lo=0x00000000; rsp_valid at acceptance+6; alu_a, alu_b and alu_sel stable for 5 cycles.
- Illegal op: op=0, then op=16 -> each gives rsp_err=1 and rsp_hi=rsp_lo=0; alu_sel stays 0 throughout.
- Backpressure: op=4 (xor), A=0xFF00FF00, B=0x0F0F0F0F, rsp_ready low for 3 cycles -> rsp_valid held with rsp_lo=0xF00FF00F stable; req_ready stays 0 until the cycle after rsp_ready; a second request waiting on req_valid is accepted afterwards.
- Reset mid-WAIT: issue op=15, assert clear 2 cycles later -> all outputs go to reset values immediately; no rsp_valid pulse; next op=1 completes normally.
- With ALU_ISSUE_DIV0_CHECK_EN defined: op=15, A=9, B=0 -> rsp_err=1 and rsp_hi=rsp_lo=0 after 1 cycle; alu_sel never 15. Without the macro: alu_sel=15 for 5 cycles and rsp_err=0.
